// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder step per clock, LSB first, valid/ready on both sides.
// Optional signed-overflow output `ovf` is enabled by defining SERIAL_ADD_OVF_EN.
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic [WIDTH-1:0] sum_sh_nxt;
  logic             carry;
  logic [CW-1:0]    count;
  logic             accept;
  logic             last_step;
  logic             bit_s;
  logic             bit_c;

  assign accept    = in_valid && in_ready;
  assign last_step = (state == RUN) && (count == CW'(WIDTH - 1));

  // 1-bit full adder on the current LSBs; new sum bit enters at the MSB end
  always_comb begin
    bit_s      = a_sh[0] ^ b_sh[0] ^ carry;
    bit_c      = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
    sum_sh_nxt = (sum_sh >> 1) | (WIDTH'(bit_s) << (WIDTH - 1));
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (accept)    next_state = RUN;
      RUN:     if (last_step) next_state = DONE;
      DONE:    if (out_ready) next_state = IDLE;
      default:                next_state = IDLE;
    endcase
  end

  // Handshake/status outputs decoded from the state register only
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state)
      IDLE:    in_ready  = 1'b1;
      RUN:     busy      = 1'b1;
      DONE: begin
        out_valid = 1'b1;
        busy      = 1'b1;
      end
      default: in_ready  = 1'b0;
    endcase
  end

  // Datapath: operand load, bit-serial shifting, result capture on the final step
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      carry  <= 1'b0;
      count  <= '0;
      sum    <= '0;
      cout   <= 1'b0;
    end else begin
      if (state == IDLE && accept) begin
        a_sh  <= a;
        b_sh  <= b;
        carry <= cin;
        count <= '0;
      end else if (state == RUN) begin
        a_sh   <= a_sh >> 1;
        b_sh   <= b_sh >> 1;
        sum_sh <= sum_sh_nxt;
        carry  <= bit_c;
        count  <= count + CW'(1);
        if (last_step) begin
          sum  <= sum_sh_nxt;
          cout <= bit_c;
        end
      end
    end
  end

`ifdef SERIAL_ADD_OVF_EN
  // Signed overflow: carry into the MSB differs from carry out of it
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            ovf <= 1'b0;
    else if (last_step) ovf <= carry ^ bit_c;
  end
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8) against an arithmetic reference model.
module tb_serial_adder;

  localparam int unsigned WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             cin = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf;
`endif

  int checks = 0;
  int errors = 0;

  serial_adder #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
`ifdef SERIAL_ADD_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain wide addition; signed overflow from operand/result signs
  task automatic model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb, input logic mc,
                       output logic [WIDTH-1:0] es, output logic ec, output logic eo);
    logic [WIDTH:0] full;
    full = {1'b0, ma} + {1'b0, mb} + (WIDTH+1)'(mc);
    es   = full[WIDTH-1:0];
    ec   = full[WIDTH];
    eo   = (ma[WIDTH-1] == mb[WIDTH-1]) && (es[WIDTH-1] != ma[WIDTH-1]);
  endtask

  // Accept one op, wait for out_valid, check latency/result, then release after `hold` cycles
  task automatic run_op(input string name, input logic [WIDTH-1:0] oa, input logic [WIDTH-1:0] ob,
                        input logic oc, input int hold);
    logic [WIDTH-1:0] es;
    logic ec, eo;
    int lat;
    model(oa, ob, oc, es, ec, eo);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s in_ready before accept: got %b want 1", name, in_ready);
    end
    in_valid = 1'b1; a = oa; b = ob; cin = oc;
    tick();
    in_valid = 1'b0; a = $urandom(); b = $urandom(); cin = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 4 * WIDTH) begin
      checks++;
      if (busy !== 1'b1 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL %s run status: busy=%b in_ready=%b want 1/0", name, busy, in_ready);
      end
      tick();
      lat++;
    end
    checks++;
    if (lat != WIDTH) begin
      errors++;
      $display("FAIL %s latency: got %0d want %0d", name, lat, WIDTH);
    end
    checks++;
    if (sum !== es || cout !== ec) begin
      errors++;
      $display("FAIL %s result: got sum=%h cout=%b want sum=%h cout=%b", name, sum, cout, es, ec);
    end
`ifdef SERIAL_ADD_OVF_EN
    checks++;
    if (ovf !== eo) begin
      errors++;
      $display("FAIL %s ovf: got %b want %b", name, ovf, eo);
    end
`endif
    for (int i = 0; i < hold; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || sum !== es || cout !== ec) begin
        errors++;
        $display("FAIL %s hold: out_valid=%b sum=%h cout=%b want 1 %h %b", name, out_valid, sum, cout, es, ec);
      end
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s release: out_valid=%b in_ready=%b busy=%b want 0 1 0", name, out_valid, in_ready, busy);
    end
  endtask

  task automatic check_reset_values(input string name);
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || sum !== '0 || cout !== 1'b0) begin
      errors++;
      $display("FAIL %s: out_valid=%b busy=%b in_ready=%b sum=%h cout=%b want 0 0 1 00 0",
               name, out_valid, busy, in_ready, sum, cout);
    end
`ifdef SERIAL_ADD_OVF_EN
    checks++;
    if (ovf !== 1'b0) begin
      errors++;
      $display("FAIL %s ovf: got %b want 0", name, ovf);
    end
`endif
  endtask

  task automatic test_reset();
    #3;
    check_reset_values("reset_initial");
    tick();
    rst = 1'b0;
    tick();
    // Produce a nonzero result, then reset asynchronously while parked in DONE
    in_valid = 1'b1; a = 8'hF0; b = 8'h20; cin = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (WIDTH) tick();
    #2 rst = 1'b1;
    #1;
    check_reset_values("reset_async_done");
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_directed();
    run_op("add_0f_01", 8'h0F, 8'h01, 1'b0, 0);
    run_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 0);
    run_op("add_7f_00_c", 8'h7F, 8'h00, 1'b1, 0);
    run_op("add_80_80", 8'h80, 8'h80, 1'b0, 1);
    run_op("add_ff_ff_c", 8'hFF, 8'hFF, 1'b1, 0);
  endtask

  task automatic test_backpressure();
    logic [WIDTH-1:0] es;
    logic ec, eo;
    model(8'h3C, 8'h5A, 1'b1, es, ec, eo);
    in_valid = 1'b1; a = 8'h3C; b = 8'h5A; cin = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (WIDTH) tick();
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; a = $urandom(); b = $urandom(); cin = 1'($urandom());
      tick();
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || sum !== es || cout !== ec) begin
        errors++;
        $display("FAIL backpressure cyc%0d: out_valid=%b in_ready=%b sum=%h cout=%b want 1 0 %h %b",
                 i, out_valid, in_ready, sum, cout, es, ec);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL backpressure release: in_ready=%b out_valid=%b busy=%b want 1 0 0", in_ready, out_valid, busy);
    end
    // Nothing taken during DONE, so the block must stay idle
    tick();
    checks++;
    if (busy !== 1'b0 || sum !== es) begin
      errors++;
      $display("FAIL backpressure no_accept: busy=%b sum=%h want 0 %h", busy, sum, es);
    end
  endtask

  task automatic test_reset_midrun();
    in_valid = 1'b1; a = 8'hAA; b = 8'h55; cin = 1'b0;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    #1;
    check_reset_values("reset_midrun");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 2 * WIDTH; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_midrun discard cyc%0d: out_valid=%b busy=%b want 0 0", i, out_valid, busy);
      end
    end
    run_op("after_reset_01_01_c", 8'h01, 8'h01, 1'b1, 0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      run_op($sformatf("random_%0d", n), WIDTH'($urandom()), WIDTH'($urandom()),
             1'($urandom()), int'($urandom_range(0, 3)));
    end
  endtask

  task automatic test_back_to_back();
    run_op("b2b_first", 8'h12, 8'h34, 1'b0, 0);
    run_op("b2b_second", 8'hC8, 8'h64, 1'b1, 0);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_midrun();
    test_random();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
